// File: rtl/sos_pkg.sv
// Shared constants for the time-shared biquad cascade:
// FSM encodings, coefficient slot indices and reset coefficient table.
package sos_pkg;

    localparam int SOS_FRAC = 18;
    localparam int NUM_COEF = 6;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_GAIN = 3'd1;
    localparam logic [2:0] S_MAC  = 3'd2;
    localparam logic [2:0] S_SAT  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [2:0] IDX_B0   = 3'd0;
    localparam logic [2:0] IDX_B1   = 3'd1;
    localparam logic [2:0] IDX_B2   = 3'd2;
    localparam logic [2:0] IDX_A1   = 3'd3;
    localparam logic [2:0] IDX_A2   = 3'd4;
    localparam logic [2:0] IDX_GAIN = 3'd5;

    // Table entries are raw bit patterns; they are truncated to COEF_SIZE on load.
    localparam int DEF_COEF [8][NUM_COEF] = '{
        '{262144, 1011590, 262144, 542396, 252999, 1176},
        '{262144,  669788, 262144, 537231, 254856, 1176},
        '{262144, 0, 0, 0, 0, 262144},
        '{262144, 0, 0, 0, 0, 262144},
        '{262144, 0, 0, 0, 0, 262144},
        '{262144, 0, 0, 0, 0, 262144},
        '{262144, 0, 0, 0, 0, 262144},
        '{262144, 0, 0, 0, 0, 262144}
    };

endpackage

// File: rtl/sos_mac.sv
// Shared multiplier with registered accumulator; rounds and saturates
// either the raw product or the accumulator back to sample width.
module sos_mac #(
    parameter int DW   = 24,
    parameter int CW   = 20,
    parameter int FRAC = 18
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clr_i,
    input  logic                 acc_en_i,
    input  logic                 neg_i,
    input  logic                 sel_acc_i,
    input  logic signed [DW-1:0] a_i,
    input  logic signed [CW-1:0] b_i,
    output logic signed [DW-1:0] q_o
);
    localparam int PW = DW + CW;
    localparam int AW = DW + CW + 3;
    localparam logic signed [AW-1:0] HALF = AW'(1) << (FRAC - 1);
    localparam logic signed [AW-1:0] MAXV = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW-1:0] MINV = ~MAXV;

    logic signed [PW-1:0] prod;
    logic signed [AW-1:0] prod_x, term, src, rnd, acc_q, acc_d;

    assign prod   = $signed({{CW{a_i[DW-1]}}, a_i}) * $signed({{DW{b_i[CW-1]}}, b_i});
    assign prod_x = {{3{prod[PW-1]}}, prod};
    assign term   = neg_i ? -prod_x : prod_x;
    assign src    = sel_acc_i ? acc_q : prod_x;
    assign rnd    = (src + HALF) >>> FRAC;

    always_comb begin
        acc_d = acc_q;
        if (clr_i)
            acc_d = '0;
        else if (acc_en_i)
            acc_d = acc_q + term;
    end

    always_comb begin
        q_o = rnd[DW-1:0];
        if (rnd > MAXV)
            q_o = MAXV[DW-1:0];
        else if (rnd < MINV)
            q_o = MINV[DW-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            acc_q <= '0;
        else
            acc_q <= acc_d;
    end

endmodule

// File: rtl/sos_cascade_scheduler.sv
// Biquad cascade: STAGES sections share one multiplier, seven cycles each
// (gain, five taps, saturate), plus one cycle to publish the result.
module sos_cascade_scheduler
    import sos_pkg::*;
#(
    parameter int COEF_SIZE = 20,
    parameter int DATA_SIZE = 24,
    parameter int STAGES    = 2,
    parameter int FRAC      = SOS_FRAC
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sample_trig,
    input  logic [DATA_SIZE-1:0] data_in,
    input  logic                 cfg_we,
    input  logic [2:0]           cfg_stage,
    input  logic [2:0]           cfg_idx,
    input  logic [COEF_SIZE-1:0] cfg_data,
    output logic [DATA_SIZE-1:0] data_out,
    output logic                 filter_end,
    output logic                 busy,
    output logic                 overrun
);
    localparam int SIW = (STAGES > 1) ? $clog2(STAGES) : 1;
    localparam logic [2:0] LAST = 3'(STAGES - 1);
    localparam logic [3:0] NST  = 4'(STAGES);

    logic [2:0]                  state_q, state_d;
    logic [2:0]                  tap_q, tap_d;
    logic [2:0]                  stage_q, stage_d;
    logic [SIW-1:0]              sidx;
    logic signed [DATA_SIZE-1:0] x_q, xg_q, data_out_q;
    logic signed [DATA_SIZE-1:0] x1_q [STAGES];
    logic signed [DATA_SIZE-1:0] x2_q [STAGES];
    logic signed [DATA_SIZE-1:0] y1_q [STAGES];
    logic signed [DATA_SIZE-1:0] y2_q [STAGES];
    logic signed [COEF_SIZE-1:0] coef_q [STAGES][NUM_COEF];
    logic                        filter_end_q, busy_q, overrun_q;
    logic signed [DATA_SIZE-1:0] mac_a, mac_q;
    logic signed [COEF_SIZE-1:0] mac_b;
    logic                        mac_clr, mac_en, mac_neg, mac_sel;
    logic                        cfg_ok;

    assign sidx   = stage_q[SIW-1:0];
    assign cfg_ok = cfg_we && !busy_q && ({1'b0, cfg_stage} < NST)
                    && (cfg_idx <= IDX_GAIN);

    always_comb begin
        state_d = state_q;
        tap_d   = tap_q;
        stage_d = stage_q;
        case (state_q)
            S_IDLE: if (sample_trig) begin
                state_d = S_GAIN;
                stage_d = '0;
            end
            S_GAIN: begin
                state_d = S_MAC;
                tap_d   = '0;
            end
            S_MAC: if (tap_q == 3'd4) state_d = S_SAT;
                   else tap_d = tap_q + 3'd1;
            S_SAT: if (stage_q == LAST) state_d = S_DONE;
                   else begin
                       stage_d = stage_q + 3'd1;
                       state_d = S_GAIN;
                   end
            default: state_d = S_IDLE;
        endcase
    end

    // Feedback taps subtract, so A1/A2 are stored with the usual sign.
    always_comb begin
        mac_a   = x_q;
        mac_b   = coef_q[sidx][IDX_GAIN];
        mac_clr = 1'b0;
        mac_en  = 1'b0;
        mac_neg = 1'b0;
        mac_sel = 1'b0;
        case (state_q)
            S_GAIN: mac_clr = 1'b1;
            S_MAC: begin
                mac_en = 1'b1;
                case (tap_q)
                    3'd0: begin mac_a = xg_q;       mac_b = coef_q[sidx][IDX_B0]; end
                    3'd1: begin mac_a = x1_q[sidx]; mac_b = coef_q[sidx][IDX_B1]; end
                    3'd2: begin mac_a = x2_q[sidx]; mac_b = coef_q[sidx][IDX_B2]; end
                    3'd3: begin mac_a = y1_q[sidx]; mac_b = coef_q[sidx][IDX_A1]; mac_neg = 1'b1; end
                    default: begin mac_a = y2_q[sidx]; mac_b = coef_q[sidx][IDX_A2]; mac_neg = 1'b1; end
                endcase
            end
            S_SAT: mac_sel = 1'b1;
            default: ;
        endcase
    end

    sos_mac #(
        .DW   (DATA_SIZE),
        .CW   (COEF_SIZE),
        .FRAC (FRAC)
    ) u_mac (
        .clk_i     (clk),
        .rst_i     (reset),
        .clr_i     (mac_clr),
        .acc_en_i  (mac_en),
        .neg_i     (mac_neg),
        .sel_acc_i (mac_sel),
        .a_i       (mac_a),
        .b_i       (mac_b),
        .q_o       (mac_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            tap_q        <= '0;
            stage_q      <= '0;
            x_q          <= '0;
            xg_q         <= '0;
            data_out_q   <= '0;
            filter_end_q <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
            for (int s = 0; s < STAGES; s++) begin
                x1_q[s] <= '0;
                x2_q[s] <= '0;
                y1_q[s] <= '0;
                y2_q[s] <= '0;
                for (int i = 0; i < NUM_COEF; i++)
                    coef_q[s][i] <= COEF_SIZE'(DEF_COEF[s][i]);
            end
        end else begin
            state_q      <= state_d;
            tap_q        <= tap_d;
            stage_q      <= stage_d;
            filter_end_q <= 1'b0;
            if (sample_trig && busy_q)
                overrun_q <= 1'b1;
            if (cfg_ok)
                coef_q[cfg_stage[SIW-1:0]][cfg_idx] <= cfg_data;
            case (state_q)
                S_IDLE: if (sample_trig) begin
                    x_q    <= data_in;
                    busy_q <= 1'b1;
                end
                S_GAIN: xg_q <= mac_q;
                S_SAT: begin
                    x2_q[sidx] <= x1_q[sidx];
                    x1_q[sidx] <= xg_q;
                    y2_q[sidx] <= y1_q[sidx];
                    y1_q[sidx] <= mac_q;
                    x_q        <= mac_q;
                end
                S_DONE: begin
                    data_out_q   <= x_q;
                    filter_end_q <= 1'b1;
                    busy_q       <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign data_out   = data_out_q;
    assign filter_end = filter_end_q;
    assign busy       = busy_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_sos_cascade_scheduler.sv
// Directed bench for the biquad cascade scheduler (STAGES=2).
module tb_sos_cascade_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        sample_trig;
    logic [23:0] data_in;
    logic        cfg_we;
    logic [2:0]  cfg_stage;
    logic [2:0]  cfg_idx;
    logic [19:0] cfg_data;
    logic [23:0] data_out;
    logic        filter_end;
    logic        busy;
    logic        overrun;

    int n_cmp = 0;
    int n_bad = 0;

    sos_cascade_scheduler dut (
        .clk         (clk),
        .reset       (reset),
        .sample_trig (sample_trig),
        .data_in     (data_in),
        .cfg_we      (cfg_we),
        .cfg_stage   (cfg_stage),
        .cfg_idx     (cfg_idx),
        .cfg_data    (cfg_data),
        .data_out    (data_out),
        .filter_end  (filter_end),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic cfg(input int s, input int i, input int v);
        cfg_we    = 1'b1;
        cfg_stage = 3'(s);
        cfg_idx   = 3'(i);
        cfg_data  = 20'(v);
        tick();
        cfg_we    = 1'b0;
    endtask

    task automatic set_pass(input int s);
        cfg(s, 0, 262144);
        cfg(s, 1, 0);
        cfg(s, 2, 0);
        cfg(s, 3, 0);
        cfg(s, 4, 0);
        cfg(s, 5, 262144);
    endtask

    task automatic set_stage0(input int b0, input int b1, input int b2,
                              input int a1, input int a2, input int g);
        cfg(0, 0, b0);
        cfg(0, 1, b1);
        cfg(0, 2, b2);
        cfg(0, 3, a1);
        cfg(0, 4, a2);
        cfg(0, 5, g);
    endtask

    // Trigger one sample; optionally write stage0 B0=1.0 mid-flight.
    task automatic run(input logic [23:0] din, input int cfg_at,
                       output logic [23:0] dout, output int lat);
        sample_trig = 1'b1;
        data_in     = din;
        tick();
        sample_trig = 1'b0;
        cfg_we      = 1'b0;
        lat = 0;
        while (!filter_end && lat < 100) begin
            if (lat == cfg_at) begin
                cfg_we = 1'b1; cfg_stage = 3'd0; cfg_idx = 3'd0; cfg_data = 20'd262144;
            end else begin
                cfg_we = 1'b0;
            end
            tick();
            lat++;
        end
        cfg_we = 1'b0;
        dout = data_out;
    endtask

    task automatic run_chk(input string tag, input logic [23:0] din,
                           input logic [23:0] exp, input int cfg_at);
        logic [23:0] d;
        int l;
        run(din, cfg_at, d, l);
        check({tag, "_lat"}, 32'(l), 32'd15);
        check(tag, {8'd0, d}, {8'd0, exp});
    endtask

    // First trigger at edge 0, a second one at edge at2.
    task automatic trig_pair(input int at2, output int nfe, output int first, output int last);
        nfe = 0; first = 0; last = 0;
        sample_trig = 1'b1;
        data_in     = 24'd1000;
        tick();
        sample_trig = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            sample_trig = (c == at2);
            tick();
            sample_trig = 1'b0;
            if (filter_end) begin
                nfe++;
                if (first == 0) first = c;
                last = c;
            end
        end
    endtask

    initial begin
        logic [23:0] d;
        int l, nfe, first, last, fe_seen;

        reset = 1'b1; sample_trig = 1'b0; data_in = '0;
        cfg_we = 1'b0; cfg_stage = '0; cfg_idx = '0; cfg_data = '0;
        tick();
        do_reset();
        check("rst_data_out", {8'd0, data_out}, 32'd0);
        check("rst_filter_end", {31'd0, filter_end}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);

        set_pass(0);
        set_pass(1);
        cfg(2, 0, 0);
        cfg(0, 6, 0);
        run_chk("pass_1000", 24'd1000, 24'd1000, -1);
        check("pass_busy_after", {31'd0, busy}, 32'd0);
        run_chk("pass_neg", 24'hFFFB2E, 24'hFFFB2E, -1);

        cfg(0, 5, 131072);
        run_chk("round_pos", 24'd3, 24'd2, -1);
        run_chk("round_neg", 24'hFFFFFD, 24'hFFFFFF, -1);

        do_reset();
        set_pass(1);
        set_stage0(0, 262144, 0, 0, 0, 262144);
        run_chk("delay_first", 24'd500, 24'd0, -1);
        run_chk("delay_second", 24'd700, 24'd500, -1);

        do_reset();
        set_pass(1);
        set_stage0(524287, 0, 0, 0, 0, 262144);
        run_chk("sat_pos", 24'h7FFFFF, 24'h7FFFFF, -1);
        run_chk("sat_neg", 24'h800000, 24'h800000, -1);

        do_reset();
        set_pass(1);
        set_stage0(262144, 65536, 131072, -131072, -65536, 262144);
        run_chk("iir_s1", 24'd1000, 24'd1000, -1);
        run_chk("iir_s2", 24'd1000, 24'd1750, -1);
        run_chk("iir_s3", 24'd0, 24'd1875, -1);

        do_reset();
        set_pass(0);
        set_pass(1);
        cfg_we = 1'b1; cfg_stage = 3'd0; cfg_idx = 3'd0; cfg_data = 20'd131072;
        run_chk("cfg_with_trig", 24'd1000, 24'd500, -1);
        run_chk("cfg_busy_cur", 24'd1000, 24'd500, 3);
        run_chk("cfg_busy_next", 24'd1000, 24'd500, -1);
        cfg(0, 0, 262144);
        run_chk("cfg_idle_takes", 24'd1000, 24'd1000, -1);

        do_reset();
        set_pass(0);
        set_pass(1);
        trig_pair(5, nfe, first, last);
        check("ovr_fe_count", 32'(nfe), 32'd1);
        check("ovr_fe_cycle", 32'(first), 32'd15);
        check("ovr_flag", {31'd0, overrun}, 32'd1);
        check("ovr_data", {8'd0, data_out}, 32'd1000);
        trig_pair(16, nfe, first, last);
        check("ovr_sticky", {31'd0, overrun}, 32'd1);
        do_reset();
        check("ovr_cleared", {31'd0, overrun}, 32'd0);

        set_pass(0);
        set_pass(1);
        trig_pair(15, nfe, first, last);
        check("done_trig_count", 32'(nfe), 32'd1);
        check("done_trig_ovr", {31'd0, overrun}, 32'd1);

        do_reset();
        set_pass(0);
        set_pass(1);
        trig_pair(16, nfe, first, last);
        check("thru_count", 32'(nfe), 32'd2);
        check("thru_second", 32'(last), 32'd31);
        check("thru_no_ovr", {31'd0, overrun}, 32'd0);

        sample_trig = 1'b1;
        data_in     = 24'd1234;
        tick();
        sample_trig = 1'b0;
        for (int c = 1; c < 8; c++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        fe_seen = 0;
        for (int c = 0; c < 20; c++) begin
            if (filter_end) fe_seen++;
            tick();
        end
        check("abort_no_fe", 32'(fe_seen), 32'd0);
        set_pass(0);
        set_pass(1);
        run_chk("abort_then_pass", 24'd1000, 24'd1000, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
